// File: rtl/bcd_pkg.sv
// Shared constants, BCD digit check and the decoded command set for the BCD counter.
// Combinational definitions only; no latency, no flow control.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_SET0,
        CMD_SET9,
        CMD_LOAD,
        CMD_UP,
        CMD_DOWN
    } cmd_t;

    function automatic logic is_bcd(input logic [3:0] nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: steps on UP/DOWN only when enabled from below, and exports ripple enables.
// Registered digit, combinational co/bo; no backpressure.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  cmd_t       cmd_i,
    input  logic       ci_i,
    input  logic       bi_i,
    input  logic [3:0] ld_nib_i,
    output logic [3:0] digit_o,
    output logic       co_o,
    output logic       bo_o
);

    logic [3:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        case (cmd_i)
            CMD_SET0: digit_d = BCD_ZERO;
            CMD_SET9: digit_d = BCD_MAX;
            CMD_LOAD: digit_d = ld_nib_i;
            CMD_UP:   if (ci_i) digit_d = (digit_q == BCD_MAX)  ? BCD_ZERO : digit_q + 4'd1;
            CMD_DOWN: if (bi_i) digit_d = (digit_q == BCD_ZERO) ? BCD_MAX  : digit_q - 4'd1;
            default:  digit_d = digit_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) digit_q <= BCD_ZERO;
        else          digit_q <= digit_d;
    end

    // Enables ripple regardless of command so the top can see terminal counts.
    assign co_o    = (digit_q == BCD_MAX)  && ci_i;
    assign bo_o    = (digit_q == BCD_ZERO) && bi_i;
    assign digit_o = digit_q;

endmodule

// File: rtl/bcd_updown_counter_n.sv
// Multi-digit BCD up/down counter with validated load and wrap/saturate at terminal counts.
// Count updates on the commanding edge; cout/bout/load_err are one-cycle registered pulses.
module bcd_updown_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  up,
    input  logic                  down,
    input  logic                  set9,
    input  logic                  set0,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  cout,
    output logic                  bout,
    output logic                  load_err
);

    cmd_t              cmd_raw, cmd_eff;
    logic              load_ok;
    logic [DIGITS:0]   ci, bi;
    logic              at_max, at_min;
    logic              cout_q, cout_d, bout_q, bout_d, load_err_q, load_err_d;

    always_comb begin
        cmd_raw = CMD_HOLD;
        if      (set0)        cmd_raw = CMD_SET0;
        else if (set9)        cmd_raw = CMD_SET9;
        else if (load)        cmd_raw = CMD_LOAD;
        else if (up && down)  cmd_raw = CMD_HOLD;
        else if (up)          cmd_raw = CMD_UP;
        else if (down)        cmd_raw = CMD_DOWN;
    end

    always_comb begin
        load_ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (!is_bcd(load_value[4*k +: 4])) load_ok = 1'b0;
        end
    end

    // A full carry/borrow out of the top decade means the count is at a terminal value.
    assign ci[0]  = 1'b1;
    assign bi[0]  = 1'b1;
    assign at_max = ci[DIGITS];
    assign at_min = bi[DIGITS];

    always_comb begin
        cmd_eff = cmd_raw;
        if (cmd_raw == CMD_LOAD && !load_ok)                  cmd_eff = CMD_HOLD;
        if (cmd_raw == CMD_UP   && at_max && (WRAP == 1'b0))  cmd_eff = CMD_HOLD;
        if (cmd_raw == CMD_DOWN && at_min && (WRAP == 1'b0))  cmd_eff = CMD_HOLD;
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clock    (clock),
            .reset_n  (reset_n),
            .cmd_i    (cmd_eff),
            .ci_i     (ci[k]),
            .bi_i     (bi[k]),
            .ld_nib_i (load_value[4*k +: 4]),
            .digit_o  (count[4*k +: 4]),
            .co_o     (ci[k+1]),
            .bo_o     (bi[k+1])
        );
    end

    always_comb begin
        cout_d     = (cmd_raw == CMD_UP)   && at_max;
        bout_d     = (cmd_raw == CMD_DOWN) && at_min;
        load_err_d = (cmd_raw == CMD_LOAD) && !load_ok;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cout_q     <= 1'b0;
            bout_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cout_q     <= cout_d;
            bout_q     <= bout_d;
            load_err_q <= load_err_d;
        end
    end

    assign cout     = cout_q;
    assign bout     = bout_q;
    assign load_err = load_err_q;

endmodule

// File: doc/bcd_updown_counter_n.md
Name: bcd_updown_counter_n

Overview:
Parametrised multi-digit BCD up/down counter. It generalises the single-digit BCD counter (up, down, set9, set0, carry/borrow out) to DIGITS cascaded decades. It adds a validated parallel load and a selectable wrap or saturate mode at the terminal counts. It sits in the display/timer datapath and drives 7-segment decoders directly, one nibble per digit.

Parameters:
DIGITS, 2, number of BCD decades; range 1..8; count width is 4*DIGITS.
WRAP, 1, 1 = wrap at terminal counts (99..9 -> 00..0, 00..0 -> 99..9); 0 = saturate at terminal counts.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
up  input  1  count up by one per clock while high.
down  input  1  count down by one per clock while high.
set9  input  1  synchronous set of all digits to 9.
set0  input  1  synchronous clear of all digits to 0.
load  input  1  synchronous parallel load request.
load_value  input  4*DIGITS  BCD value to load; digit 0 is in bits [3:0].
count  output  4*DIGITS  current BCD count; digit 0 is in bits [3:0]; registered.
cout  output  1  registered carry pulse, one cycle.
bout  output  1  registered borrow pulse, one cycle.
load_err  output  1  registered pulse, one cycle; the load was rejected because it held a non-BCD digit.

Behaviour:
- Clocking and reset: one clock domain (clock). reset_n is asynchronous and active-low.
- Reset values: count = 0, cout = 0, bout = 0, load_err = 0. Outputs take these values immediately when reset_n falls. Deasserting reset mid-count resumes from 0.
- Priority per rising edge: set0 > set9 > load > (up and down both high: hold) > up > down > hold.
- set0: count = all 0.
- set9: count = all 9.
- Neither set0 nor set9 raises cout or bout.
- load, all nibbles <= 9: count = load_value; load_err = 0.
- load, any nibble > 9: count holds; load_err = 1 for the next cycle only. The load is all-or-nothing; no partial load.
- Up step: digit 0 increments. Digit k increments only if every lower digit was 9. A digit at 9 that increments becomes 0.
- Down step: digit 0 decrements. Digit k decrements only if every lower digit was 0. A digit at 0 that decrements becomes 9.
- Carry/borrow chain: combinational ripple through the digits inside one cycle. No extra latency; count updates on the same edge as the command.
- Up at all-9:
  - WRAP=1: count becomes all 0.
  - WRAP=0: count holds all 9.
  - Either mode: cout = 1 for exactly the following cycle.
- Down at all-0:
  - WRAP=1: count becomes all 9.
  - WRAP=0: count holds all 0.
  - Either mode: bout = 1 for exactly the following cycle.
- Held up/down at a terminal count with WRAP=0: cout/bout pulse on every attempted step, so they stay high continuously.
- cout, bout and load_err are otherwise 0. They are never high in the same cycle as each other.
- Internal count is never a non-BCD value. Any out-of-range digit would need a reset; it is unreachable by construction.

Decomposition:
- Package bcd_pkg:
  - BCD_MAX = 4'd9, BCD_ZERO = 4'd0.
  - Function is_bcd(nibble).
  - Enumerated command type cmd_t: CMD_HOLD, CMD_SET0, CMD_SET9, CMD_LOAD, CMD_UP, CMD_DOWN. Produced by the priority decoder.
- Sub-module bcd_digit: one decade.
  - Inputs: cmd, ci (increment enable from below), bi (decrement enable from below), load nibble.
  - Outputs: digit register, co (digit==9 and ci), bo (digit==0 and bi).
  - Generate-instantiated DIGITS times.
  - Top level holds the command decode, load validation, the terminal/saturate override and the pulse registers.

Test Plan (DIGITS=2 unless stated):
1. Reset: count to 0x37, drop reset_n between edges -> count=0x00, cout=bout=load_err=0 immediately. Release -> up resumes 0x01, 0x02.
2. Up wrap: set0, then up for 100 edges -> count steps 0x00..0x99, returns to 0x00 on the 100th edge. cout=1 for exactly that one cycle; bout=0 throughout.
3. Down wrap: set9 -> 0x99; down -> 0x98 … 0x90 -> 0x89 (tens borrow). From 0x00, down -> 0x99 with bout=1 for one cycle.
4. Priority: at 0x45, up=down=1 -> holds 0x45. set0=set9=up=load=1 -> 0x00. set9=load=1 with load_value=0x12 -> 0x99.
5. Load check: load 0x57 -> count 0x57, load_err=0. Load 0x5A -> count stays 0x57, load_err=1 one cycle. Load 0xA0 -> same rejection.
6. WRAP=0, DIGITS=3: set9 then up x3 -> count stays 0x999, cout high all three cycles. set0 then down -> stays 0x000, bout=1.
